// File: rtl/longop_issue_controller.sv
// Purpose: sequences multi-cycle FPU / crypto-core ops beside the EX stage.
//   It freezes the front end, pulses the unit start, waits for done and
//   releases the instruction with a one-cycle result strobe.
// Latency: the issue is accepted in IDLE, START follows one cycle later,
//   and result_valid fires one cycle after done is seen.
// Backpressure: stall holds PC, IF/ID and ID/EX while a unit is owned.
//   During ABORT, stall only holds a newly arriving long op.
// Ports:
//   clk, rst                    clock, async active-high reset
//   issue_valid, issue_unit     ID/EX instruction and unit select (0=ALU, 1=FPU, 2=crypto, 3=rsvd)
//   flush                       kill the instruction in the long-op slot
//   fpu_done, crypto_done       unit completion pulses
//   fpu_start, crypto_start     one-cycle start pulses
//   stall, bubble               front-end hold / EX-MEM write suppression
//   result_valid                EX/MEM captures the unit result this cycle
//   busy, active_unit           a unit is owned / latched unit code
//   timeout_err                 sticky: a forced release happened
module longop_issue_controller #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [1:0] issue_unit,
  input  logic       flush,
  input  logic       fpu_done,
  input  logic       crypto_done,
  output logic       fpu_start,
  output logic       crypto_start,
  output logic       stall,
  output logic       bubble,
  output logic       result_valid,
  output logic       busy,
  output logic [1:0] active_unit,
  output logic       timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    unit_q, unit_d;
  logic          err_q, err_d;

  logic          issue_long;
  logic          unit_done;
  logic          timed_out;
  logic [CW-1:0] cnt_inc;

  // Only FPU and crypto are long ops; the reserved code behaves like ALU.
  assign issue_long = issue_valid && (issue_unit == 2'd1 || issue_unit == 2'd2);
  // Completion from the unit we do not own is ignored.
  assign unit_done  = (unit_q == 2'd1 && fpu_done) || (unit_q == 2'd2 && crypto_done);
  // The counter holds the number of WAIT/ABORT cycles already completed, so
  // reaching LAST marks the final permitted cycle. Using >= covers the case
  // where the counter has moved past LAST while the slot was aborting.
  assign timed_out  = (cnt_q >= CNT_LAST);
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      unit_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      unit_q  <= unit_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    unit_d       = unit_q;
    err_d        = err_q;
    fpu_start    = 1'b0;
    crypto_start = 1'b0;
    stall        = 1'b0;
    bubble       = 1'b0;
    result_valid = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (issue_long && !flush) begin
          unit_d  = issue_unit;
          state_d = S_START;
        end
      end
      S_START: begin
        stall        = 1'b1;
        bubble       = 1'b1;
        fpu_start    = (unit_q == 2'd1);
        crypto_start = (unit_q == 2'd2);
        cnt_d        = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        stall  = 1'b1;
        bubble = 1'b1;
        cnt_d  = cnt_inc;
        // flush beats done; done on the last cycle beats the timeout.
        if (flush) begin
          state_d = S_ABORT;
        end else if (unit_done) begin
          state_d = S_DONE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        result_valid = !flush;
        bubble       = flush;
        unit_d       = 2'd0;
        state_d      = S_IDLE;
      end
      S_ABORT: begin
        // The unit is still running, so a new long op has to wait for it.
        stall  = issue_long;
        bubble = issue_long;
        cnt_d  = cnt_inc;
        if (unit_done) begin
          unit_d  = 2'd0;
          state_d = S_IDLE;
        end else if (timed_out) begin
          err_d   = 1'b1;
          unit_d  = 2'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        unit_d  = 2'd0;
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign active_unit = unit_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_longop_issue_controller.sv
// Self-checking bench for longop_issue_controller with a small timeout.
// Each cycle, the DUT outputs are compared with a phase-flag reference model.
module tb_longop_issue_controller;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_valid = 1'b0;
  logic [1:0] issue_unit = 2'd0;
  logic       flush = 1'b0;
  logic       fpu_done = 1'b0;
  logic       crypto_done = 1'b0;
  logic       fpu_start, crypto_start, stall, bubble, result_valid, busy, timeout_err;
  logic [1:0] active_unit;

  int vectors = 0;
  int miss = 0;

  longop_issue_controller #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_unit(issue_unit),
    .flush(flush), .fpu_done(fpu_done), .crypto_done(crypto_done),
    .fpu_start(fpu_start), .crypto_start(crypto_start), .stall(stall),
    .bubble(bubble), .result_valid(result_valid), .busy(busy),
    .active_unit(active_unit), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model. The slot is described by phase flags and by the total
  // number of cycles the unit has been running (WAIT plus ABORT).
  int m_unit;
  bit m_start, m_wait, m_rel, m_abort, m_err;
  int m_run;

  function automatic void model_reset();
    m_unit = 0; m_start = 0; m_wait = 0; m_rel = 0; m_abort = 0; m_err = 0; m_run = 0;
  endfunction

  function automatic bit is_long(input logic iv, input logic [1:0] u);
    return iv && (u == 2'd1 || u == 2'd2);
  endfunction

  // {fpu_start, crypto_start, stall, bubble, result_valid, busy, active_unit, timeout_err}
  function automatic logic [8:0] exp_out();
    logic held, st, bb, rv, bz;
    held = m_abort && is_long(issue_valid, issue_unit);
    st   = m_start || m_wait || held;
    bb   = m_start || m_wait || held || (m_rel && flush);
    rv   = m_rel && !flush;
    bz   = m_start || m_wait || m_rel || m_abort;
    return {m_start && m_unit == 1, m_start && m_unit == 2, st, bb, rv, bz,
            2'(m_unit), m_err};
  endfunction

  function automatic logic [8:0] observed();
    return {fpu_start, crypto_start, stall, bubble, result_valid, busy, active_unit, timeout_err};
  endfunction

  function automatic void model_step();
    bit own_done;
    own_done = (m_unit == 1 && fpu_done) || (m_unit == 2 && crypto_done);
    if (m_start) begin
      m_start = 0; m_wait = 1; m_run = 0;
    end else if (m_wait) begin
      m_run++;
      if (flush) begin
        m_wait = 0; m_abort = 1;
      end else if (own_done) begin
        m_wait = 0; m_rel = 1;
      end else if (m_run >= T) begin
        m_wait = 0; m_rel = 1; m_err = 1;
      end
    end else if (m_rel) begin
      m_rel = 0; m_unit = 0;
    end else if (m_abort) begin
      m_run++;
      if (own_done) begin
        m_abort = 0; m_unit = 0;
      end else if (m_run >= T) begin
        m_abort = 0; m_unit = 0; m_err = 1;
      end
    end else if (is_long(issue_valid, issue_unit) && !flush) begin
      m_unit = int'(issue_unit); m_start = 1;
    end
  endfunction

  task automatic drive(input logic iv, input logic [1:0] u, input logic fl,
                       input logic fd, input logic cd);
    issue_valid = iv; issue_unit = u; flush = fl; fpu_done = fd; crypto_done = cd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (observed() !== 9'd0) begin
      miss++; $display("FAIL reset: got %b want %b", observed(), 9'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_reserved();
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, (k % 2 == 0) ? 2'd0 : 2'd3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      vectors++;
      if (observed() !== exp_out()) begin
        miss++; $display("FAIL alu_reserved cyc %0d: got %b want %b", k, observed(), exp_out());
      end
      vectors++;
      if ({fpu_start, crypto_start, stall} !== 3'b000) begin
        miss++; $display("FAIL alu_reserved_nostart cyc %0d: got %b want 000", k, {fpu_start, crypto_start, stall});
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  // FPU op with done raised six cycles after START: 1 START + 6 WAIT cycles of stall.
  task automatic test_fpu_op();
    int n_start, n_stall, n_rv;
    n_start = 0; n_stall = 0; n_rv = 0;
    for (int k = 0; k < 11; k++) begin
      drive(k == 0, 2'd1, 1'b0, k == 7, 1'b0);
      @(negedge clk);
      vectors++;
      if (observed() !== exp_out()) begin
        miss++; $display("FAIL fpu_op cyc %0d: got %b want %b", k, observed(), exp_out());
      end
      n_start += int'(fpu_start); n_stall += int'(stall); n_rv += int'(result_valid);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    vectors++;
    if (n_start != 1 || n_stall != 7 || n_rv != 1) begin
      miss++; $display("FAIL fpu_op_counts: got start=%0d stall=%0d rv=%0d want 1 7 1", n_start, n_stall, n_rv);
    end
  endtask

  task automatic test_other_done_ignored();
    for (int k = 0; k < 10; k++) begin
      drive(k == 0, 2'd1, 1'b0, k == 6, k == 3 || k == 4);
      @(negedge clk);
      vectors++;
      if (observed() !== exp_out()) begin
        miss++; $display("FAIL other_done cyc %0d: got %b want %b", k, observed(), exp_out());
      end
      if (k == 5) begin
        vectors++;
        if ({busy, stall, active_unit} !== 4'b1101) begin
          miss++; $display("FAIL other_done_still_wait: got %b want 1101", {busy, stall, active_unit});
        end
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  // Flush during WAIT, then a crypto issue is held until the FPU finishes.
  task automatic test_abort_hold();
    for (int k = 0; k < 17; k++) begin
      drive(k == 0 || (k >= 4 && k <= 8), (k == 0) ? 2'd1 : 2'd2, k == 3, k == 7, k == 12);
      @(negedge clk);
      vectors++;
      if (observed() !== exp_out()) begin
        miss++; $display("FAIL abort_hold cyc %0d: got %b want %b", k, observed(), exp_out());
      end
      if (k == 9) begin
        vectors++;
        if (crypto_start !== 1'b1) begin
          miss++; $display("FAIL abort_hold_crypto_start: got %b want 1", crypto_start);
        end
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 14; k++) begin
      drive(k == 0, 2'd2, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      vectors++;
      if (observed() !== exp_out()) begin
        miss++; $display("FAIL timeout cyc %0d: got %b want %b", k, observed(), exp_out());
      end
      tick();
    end
    vectors++;
    if ({timeout_err, busy} !== 2'b10) begin
      miss++; $display("FAIL timeout_sticky: got %b want 10", {timeout_err, busy});
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin
      drive(k == 0, 2'd1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      vectors++;
      if (observed() !== exp_out()) begin
        miss++; $display("FAIL async_pre cyc %0d: got %b want %b", k, observed(), exp_out());
      end
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (observed() !== 9'd0) begin
      miss++; $display("FAIL async_reset_now: got %b want %b", observed(), 9'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 2'd0, 1'b0, 1'b1, k == 2);
      @(negedge clk);
      vectors++;
      if (observed() !== exp_out()) begin
        miss++; $display("FAIL async_post cyc %0d: got %b want %b", k, observed(), exp_out());
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(1, 0) == 1, 2'($urandom_range(3, 0)), $urandom_range(15, 0) == 0,
            $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0);
      @(negedge clk);
      vectors++;
      if (observed() !== exp_out()) begin
        miss++; $display("FAIL random cyc %0d: got %b want %b", k, observed(), exp_out());
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_alu_reserved();
    test_fpu_op();
    test_other_done_ignored();
    test_abort_hold();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule
